accel_sched: RTL and testbench

ACCEL_SCHED -- requirements
Module: accel_sched

---
 rtl/accel_sched.sv | 160 ++++++++++++++++
 tb/tb_accel_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/accel_sched.sv
// accel_sched: round-robin scheduler that shares one compute core among four
// requesters. One job at a time moves through IDLE -> LAUNCH -> WAIT -> RESP.
// The core is watched with a saturating wait counter; a job that runs past
// TIMEOUT is aborted and reported with err.
module accel_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_cfg,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done_pulse,
  output logic [NREQ-1:0]    err,
  output logic [DW-1:0]      rsp_data,
  output logic               core_start,
  output logic [DW-1:0]      core_cfg,
  input  logic               core_done,
  input  logic [DW-1:0]      core_result,
  output logic [3:0]         status
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        idx_q, idx_d;
  logic [DW-1:0]     cfg_q, cfg_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_l_q, err_l_d;
  logic              sticky_q, sticky_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [DW-1:0]     rsp_q, rsp_d;
  logic              start_q, start_d;

  logic [1:0]        win;
  logic              found;
  logic [7:0]        cnt_inc;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    win   = rr_ptr_q;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[2'(rr_ptr_q + 2'(i))]) begin
        win   = 2'(rr_ptr_q + 2'(i));
        found = 1'b1;
      end
    end
  end

  // Counter never wraps, so a long-stalled core still times out.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Next-state and next-output computation for the job FSM.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    err_l_d  = err_l_q;
    sticky_d = sticky_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = '0;
    rsp_d    = '0;
    start_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (found) begin
          idx_d   = win;
          cfg_d   = req_cfg[int'(win)*DW +: DW];
          grant_d = onehot(win);
          start_d = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // A completion on the timeout cycle still counts as success.
        if (core_done) begin
          err_l_d = 1'b0;
          done_d  = onehot(idx_q);
          rsp_d   = core_result;
          state_d = S_RESP;
        end else if (cnt_inc >= 8'(TIMEOUT)) begin
          err_l_d = 1'b1;
          done_d  = onehot(idx_q);
          err_d   = onehot(idx_q);
          rsp_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        sticky_d = sticky_q | err_l_q;
        rr_ptr_d = 2'(idx_q + 2'd1);
        grant_d  = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight job silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      cfg_q    <= '0;
      cnt_q    <= '0;
      err_l_q  <= 1'b0;
      sticky_q <= 1'b0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rsp_q    <= '0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      err_l_q  <= err_l_d;
      sticky_q <= sticky_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rsp_q    <= rsp_d;
      start_q  <= start_d;
    end
  end

  assign grant      = grant_q;
  assign done_pulse = done_q;
  assign err        = err_q;
  assign rsp_data   = rsp_q;
  assign core_start = start_q;
  assign core_cfg   = cfg_q;
  assign status     = {idx_q, (state_q != S_IDLE), sticky_q};

endmodule

// File: tb/tb_accel_sched.sv
// Randomized bench for accel_sched with a job-level reference model:
// the model tracks only the round-robin pointer and sticky error, and derives
// each job's winner, completion cycle and result from the latency rules.
module tb_accel_sched;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] req_cfg = '0;
  logic [3:0]  grant, done_pulse, err;
  logic [15:0] rsp_data, core_cfg, core_result = '0;
  logic        core_start, core_done = 1'b0;
  logic [3:0]  status;

  accel_sched #(.NREQ(4), .DW(16), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cfg(req_cfg),
    .grant(grant), .done_pulse(done_pulse), .err(err), .rsp_data(rsp_data),
    .core_start(core_start), .core_cfg(core_cfg), .core_done(core_done),
    .core_result(core_result), .status(status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int rr = 0;
  bit sticky = 1'b0;
  logic [15:0] cfgs [4];
  int resp_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] rv, input int ptr);
    for (int i = 0; i < 4; i++)
      if (rv[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_done"}, done_pulse, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rsp"}, rsp_data, 0);
    chk({tag, "_start"}, core_start, 0);
    chk({tag, "_cfg"}, core_cfg, 0);
    chk({tag, "_status"}, status, 0);
  endtask

  // Called in an IDLE cycle; d = core_done delay after core_start (0 = never).
  task automatic run_job(input logic [3:0] rv, input int d, input logic [15:0] res,
                         input bit drop, input bit stray);
    int w, r;
    bit e;
    logic [3:0] oh;
    logic [1:0] wl;
    w  = pick(rv, rr);
    wl = w[1:0];
    oh = 4'b0001 << w;
    e  = !(d >= 1 && d <= T);
    r  = e ? T + 1 : d + 1;
    for (int i = 0; i < 4; i++) req_cfg[i*16 +: 16] = cfgs[i];
    req = rv;
    core_done = stray;
    core_result = 16'($urandom);
    step();  // LAUNCH
    chk("launch_start", core_start, 1);
    chk("launch_grant", grant, oh);
    chk("launch_cfg", core_cfg, cfgs[w]);
    chk("launch_busy", status[1], 1);
    core_done = 1'($urandom_range(0, 1));
    req = 4'($urandom) | oh;
    req_cfg = {$urandom, $urandom};
    for (int c = 1; c < r; c++) begin
      step();  // WAIT
      chk("wait_grant", grant, oh);
      chk("wait_done", done_pulse, 0);
      chk("wait_start", core_start, 0);
      core_done = (c == d);
      core_result = res;
      if (drop && c == 1) req[w] = 1'b0;
      req_cfg = {$urandom, $urandom};
    end
    step();  // RESP
    core_done = 1'b0;
    chk("resp_done", done_pulse, oh);
    chk("resp_err", err, e ? oh : 4'b0);
    chk("resp_data", rsp_data, e ? 16'h0 : res);
    chk("resp_grant", grant, oh);
    chk("resp_cfg", core_cfg, cfgs[w]);
    resp_cyc = cyc;
    rr = (w + 1) % 4;
    sticky = sticky | e;
    step();  // IDLE
    chk("idle_done", done_pulse, 0);
    chk("idle_err", err, 0);
    chk("idle_rsp", rsp_data, 0);
    chk("idle_grant", grant, 0);
    chk("idle_status", status, {wl, 1'b0, sticky});
    req[w] = 1'b0;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) begin
      core_done = 1'($urandom_range(0, 1));
      step();
      chk("gap_grant", grant, 0);
      chk("gap_busy", status[1], 0);
      chk("gap_done", done_pulse, 0);
    end
    core_done = 1'b0;
  endtask

  initial begin
    int prev;
    for (int i = 0; i < 4; i++) cfgs[i] = 16'($urandom);
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // fairness: all requesters held, core answers one cycle after start
    for (int j = 0; j < 5; j++) begin
      prev = resp_cyc;
      run_job(4'b1111, 1, 16'($urandom), 1'b0, 1'b0);
      if (j > 0) chk("fair_spacing", resp_cyc - prev, 4);
    end
    chk("fair_rr", rr, 1);

    // single job with known config and result
    cfgs[1] = 16'h00A5;
    run_job(4'b0010, 3, 16'h1234, 1'b0, 1'b0);
    idle(1);

    // timeout, then tie on the timeout cycle
    run_job(4'b0001, 0, 16'hBEEF, 1'b0, 1'b0);
    idle(2);
    run_job(4'b0011, T, 16'h5A5A, 1'b0, 1'b0);

    // owner drops req mid-job, stray core_done in IDLE
    run_job(4'b0100, 5, 16'hC0DE, 1'b1, 1'b1);
    idle(3);
    run_job(4'b0100, 2, 16'h7777, 1'b0, 1'b0);  // leaves rr = 3

    // reset in the middle of WAIT
    req = 4'b0110;
    step();
    step();
    step();
    rst_n = 1'b0;
    core_done = 1'b1;
    core_result = 16'hFFFF;
    step();
    chk_zero("midwait_rst");
    rst_n = 1'b1;
    core_done = 1'b0;
    req = '0;
    step();
    chk_zero("post_rst");
    rr = 0;
    sticky = 1'b0;
    run_job(4'b1010, 2, 16'h0101, 1'b0, 1'b0);
    run_job(4'b1000, 4, 16'h0808, 1'b0, 1'b0);

    // randomized jobs
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < 4; i++) cfgs[i] = 16'($urandom);
      run_job(4'($urandom_range(1, 15)), $urandom_range(0, T + 2), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
